// File: rtl/aes_loader_pkg.sv
// Shared constants and types for the AES block loader.
package aes_loader_pkg;

  localparam int NUMBITS_DEF    = 8;
  localparam int BLOCKBYTES_DEF = 16;
  // Width of the byte counter: must hold 0..BLOCKBYTES inclusive.
  localparam int CNT_W          = $clog2(BLOCKBYTES_DEF + 1);
  // Width of the blk_nbytes output.
  localparam int NBYTES_W       = 5;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/blk_byte_shifter.sv
// Block register for the AES loader: writes one byte at a given position
// (position 0 lands in the most significant byte) and clears on request.
module blk_byte_shifter #(
  parameter int NUMBITS    = 8,
  parameter int BLOCKBYTES = 16,
  parameter int CW         = $clog2(BLOCKBYTES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [CW-1:0]                 wr_pos,
  input  logic [NUMBITS-1:0]            wr_data,
  output logic [NUMBITS*BLOCKBYTES-1:0] blk_data
);

  logic [NUMBITS*BLOCKBYTES-1:0] blk_q;

  // Block register: clear has priority over a same-cycle byte write.
  // NOTE: this register is reset explicitly because unfilled bytes of a
  // flushed block must read as zero; a plain RAM would not give that.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      blk_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BLOCKBYTES; i++) begin
        if (wr_pos == CW'(i)) begin
          blk_q[(BLOCKBYTES-1-i)*NUMBITS +: NUMBITS] <= wr_data;
        end
      end
    end
  end

  assign blk_data = blk_q;

endmodule

// File: rtl/aes_block_loader.sv
// Assembles bytes popped from a byte FIFO into AES blocks and presents them
// with a valid/ready handshake. A flush pulse closes a partial block.
// Optional feature macro: AES_LOADER_ZERO_PAD_EN -- when defined, a flushed
// partial block is emitted with its unfilled bytes reading zero; when
// undefined, a flushed partial block is discarded.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int NUMBITS    = NUMBITS_DEF,
  parameter int BLOCKBYTES = BLOCKBYTES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_empty,
  input  logic [NUMBITS-1:0]            fifo_r_data,
  output logic                          fifo_r_enable,
  input  logic                          flush,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [NUMBITS*BLOCKBYTES-1:0] blk_data,
  output logic                          blk_last,
  output logic [NBYTES_W-1:0]           blk_nbytes
);

  localparam int CW = $clog2(BLOCKBYTES + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                last_q, last_d;
  logic [NBYTES_W-1:0] nb_q, nb_d;
  logic                pop;
  logic                clr;

  // Next-state, counter and block-close decisions.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    nb_d    = nb_q;
    pop     = 1'b0;
    clr     = 1'b0;
    cnt_inc = '0;
    unique case (state_q)
      FILL: begin
        pop     = !fifo_empty;
        cnt_inc = cnt_q + CW'(pop);
        cnt_d   = cnt_inc;
        if (pop && (cnt_inc == CW'(BLOCKBYTES))) begin
          // Full block; a coincident flush only marks it as last.
          state_d = PRESENT;
          last_d  = flush;
          nb_d    = NBYTES_W'(BLOCKBYTES);
        end else if (flush && (cnt_inc != '0)) begin
`ifdef AES_LOADER_ZERO_PAD_EN
          // Unfilled positions already read zero: the register is cleared
          // on every handshake and reset.
          state_d = PRESENT;
          last_d  = 1'b1;
          nb_d    = NBYTES_W'(cnt_inc);
`else
          // Partial block is dropped, including a same-cycle popped byte.
          cnt_d   = '0;
          clr     = 1'b1;
`endif
        end
      end
      PRESENT: begin
        if (blk_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          last_d  = 1'b0;
          nb_d    = '0;
          clr     = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, counter and block metadata registers.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      nb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      nb_q    <= nb_d;
    end
  end

  blk_byte_shifter #(
    .NUMBITS    (NUMBITS),
    .BLOCKBYTES (BLOCKBYTES),
    .CW         (CW)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (pop),
    .wr_pos   (cnt_q),
    .wr_data  (fifo_r_data),
    .blk_data (blk_data)
  );

  // Strobes are masked during reset so they drop in the reset cycle itself.
  assign fifo_r_enable = pop && !rst;
  assign blk_valid     = (state_q == PRESENT) && !rst;
  assign blk_last      = last_q;
  assign blk_nbytes    = nb_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: a directed vector table, hand
// sequences for multi-cycle cases, and randomized traffic against a
// byte-queue reference model. Honours AES_LOADER_ZERO_PAD_EN.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [7:0]   fifo_r_data = 8'h00;
  logic         flush = 1'b0;
  logic         blk_ready = 1'b0;
  logic         fifo_r_enable;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_last;
  logic [4:0]   blk_nbytes;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_block_loader dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_r_data   (fifo_r_data),
    .fifo_r_enable (fifo_r_enable),
    .flush         (flush),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .blk_data      (blk_data),
    .blk_last      (blk_last),
    .blk_nbytes    (blk_nbytes)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte queue + pending block) ----------
  logic [7:0]   m_part[$];
  logic         m_valid = 1'b0;
  logic [127:0] m_data  = '0;
  logic         m_last  = 1'b0;
  logic [4:0]   m_nb    = '0;

  logic         obs_valid, obs_last, obs_ren;
  logic [127:0] obs_data;
  logic [4:0]   obs_nb;

  function automatic logic [127:0] pack_part();
    logic [127:0] p = '0;
    for (int i = 0; i < m_part.size(); i++) p[127-8*i -: 8] = m_part[i];
    return p;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic r, input logic e, input logic [7:0] d,
                      input logic f, input logic rdy);
    @(negedge clk);
    rst = r; fifo_empty = e; fifo_r_data = d; flush = f; blk_ready = rdy;
    #1;
    obs_valid = blk_valid; obs_last = blk_last; obs_ren = fifo_r_enable;
    obs_data  = blk_data;  obs_nb   = blk_nbytes;
    check1("ren", fifo_r_enable, !r && !m_valid && !e);
    check1("valid", blk_valid, !r && m_valid);
    if (!r && m_valid) begin
      check("data", blk_data, m_data);
      check1("last", blk_last, m_last);
      check("nbytes", 128'(blk_nbytes), 128'(m_nb));
    end
    if (r) begin
      m_part.delete();
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (rdy) m_valid = 1'b0;
    end else begin
      if (!e) m_part.push_back(d);
      if (m_part.size() == 16) begin
        m_valid = 1'b1; m_data = pack_part(); m_last = f; m_nb = 5'd16;
        m_part.delete();
      end else if (f && m_part.size() > 0) begin
`ifdef AES_LOADER_ZERO_PAD_EN
        m_valid = 1'b1; m_data = pack_part(); m_last = 1'b1;
        m_nb = 5'(m_part.size());
`endif
        m_part.delete();
      end
    end
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic r, e; logic [7:0] d; logic f, rdy;
    logic ren, valid, last; logic [4:0] nb; logic meta;
    logic chk_data; logic [127:0] dat;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic r, e, input logic [7:0] d, input logic f, rdy,
                              input logic ren, v, l, input logic [4:0] nb, input logic meta);
    vec_t x;
    x.r = r; x.e = e; x.d = d; x.f = f; x.rdy = rdy;
    x.ren = ren; x.valid = v; x.last = l; x.nb = nb; x.meta = meta;
    x.chk_data = 1'b0; x.dat = '0;
    return x;
  endfunction

  localparam logic [127:0] BLK30 = 128'h303132333435363738393a3b3c3d3e3f;
  localparam logic [127:0] BLK00 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK10 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] BLK40 = 128'h404142434445464748494a4b4c4d4e4f;
  localparam logic [127:0] BLK60 = 128'h606162636465666768696a6b6c6d6e6f;
  localparam logic [127:0] BLKA1 = 128'ha1a2a300000000000000000000000000;

  logic [7:0] src[$];
  logic       mv, rdy_v, e_v, r_v, f_v, pop_pred;
  logic [7:0] d_v;
  int         k, hold, nblk;

  initial begin
    // Table: reset, flush on empty, flush on 16th pop, PRESENT stall, reset mid-fill.
    tbl[0] = mk(1, 0, 8'h55, 0, 0, 0, 0, 0, 5'd0, 1);
    tbl[1] = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 5'd0, 1);
    tbl[2] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 5'd0, 1);
    for (int i = 0; i < 16; i++)
      tbl[3+i] = mk(0, 0, 8'(8'h30 + i), (i == 15), 0, 1, 0, 0, 5'd0, 0);
    tbl[19] = mk(0, 0, 8'h99, 1, 0, 0, 1, 1, 5'd16, 1);
    tbl[19].chk_data = 1'b1; tbl[19].dat = BLK30;
    tbl[20] = mk(0, 1, 8'h00, 0, 1, 0, 1, 1, 5'd16, 1);
    tbl[20].chk_data = 1'b1; tbl[20].dat = BLK30;
    tbl[21] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 5'd0, 0);
    tbl[21].chk_data = 1'b1;
    tbl[22] = mk(0, 0, 8'h77, 0, 0, 1, 0, 0, 5'd0, 0);
    tbl[23] = mk(1, 0, 8'h78, 0, 0, 0, 0, 0, 5'd0, 0);
    tbl[24] = mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 5'd0, 1);
    tbl[24].chk_data = 1'b1;

    repeat (3) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst = tbl[i].r; fifo_empty = tbl[i].e; fifo_r_data = tbl[i].d;
      flush = tbl[i].f; blk_ready = tbl[i].rdy;
      #1;
      check1($sformatf("tbl%0d_ren", i), fifo_r_enable, tbl[i].ren);
      check1($sformatf("tbl%0d_valid", i), blk_valid, tbl[i].valid);
      if (tbl[i].meta) begin
        check1($sformatf("tbl%0d_last", i), blk_last, tbl[i].last);
        check($sformatf("tbl%0d_nbytes", i), 128'(blk_nbytes), 128'(tbl[i].nb));
      end
      if (tbl[i].chk_data)
        check($sformatf("tbl%0d_data", i), blk_data, tbl[i].dat);
    end

    // Minimum latency: 16 back-to-back pops, valid on cycle 17.
    for (int i = 0; i < 16; i++) step(0, 0, 8'(i), 0, 1);
    check1("lat_c16_valid", obs_valid, 1'b0);
    step(0, 1, 8'h00, 0, 1);
    check1("lat_c17_valid", obs_valid, 1'b1);
    check("lat_data", obs_data, BLK00);
    check1("lat_last", obs_last, 1'b0);
    check("lat_nbytes", 128'(obs_nb), 128'd16);

    // Two blocks with a 5-cycle ready stall on each.
    k = 0; hold = 0; nblk = 0;
    for (int c = 0; c < 60; c++) begin
      e_v = (k >= 32);
      mv = m_valid;
      rdy_v = mv && (hold >= 5);
      pop_pred = !mv && !e_v;
      step(0, e_v, 8'(k), 0, rdy_v);
      if (pop_pred) k++;
      if (mv) begin
        if (rdy_v) begin
          if (nblk == 0) check("stall_b0_data", obs_data, BLK00);
          else check("stall_b1_data", obs_data, BLK10);
          nblk++;
          hold = 0;
        end else begin
          hold++;
        end
      end
    end
    check("stall_nblocks", 128'(nblk), 128'd2);

    // Partial block of three bytes, then flush.
    step(0, 0, 8'hA1, 0, 0);
    step(0, 0, 8'hA2, 0, 0);
    step(0, 0, 8'hA3, 0, 0);
    step(0, 1, 8'h00, 1, 0);
    step(0, 1, 8'h00, 0, 0);
`ifdef AES_LOADER_ZERO_PAD_EN
    check1("pad_valid", obs_valid, 1'b1);
    check("pad_data", obs_data, BLKA1);
    check1("pad_last", obs_last, 1'b1);
    check("pad_nbytes", 128'(obs_nb), 128'd3);
    step(0, 1, 8'h00, 0, 1);
`else
    check1("discard_valid", obs_valid, 1'b0);
`endif
    for (int i = 0; i < 16; i++) step(0, 0, 8'(8'h40 + i), 0, 1);
    step(0, 1, 8'h00, 0, 1);
    check1("after_flush_valid", obs_valid, 1'b1);
    check("after_flush_data", obs_data, BLK40);
    check1("after_flush_last", obs_last, 1'b0);

    // Reset after seven pops discards the partial block.
    for (int i = 0; i < 7; i++) step(0, 0, 8'(8'h50 + i), 0, 1);
    step(1, 0, 8'h57, 0, 1);
    check1("rst_ren", obs_ren, 1'b0);
    check1("rst_valid", obs_valid, 1'b0);
    step(1, 0, 8'h57, 0, 1);
    check1("rst_last", obs_last, 1'b0);
    check("rst_nbytes", 128'(obs_nb), 128'd0);
    check("rst_data", obs_data, 128'd0);
    for (int i = 0; i < 16; i++) step(0, 0, 8'(8'h60 + i), 0, 1);
    step(0, 1, 8'h00, 0, 1);
    check1("post_rst_valid", obs_valid, 1'b1);
    check("post_rst_data", obs_data, BLK60);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if (src.size() < 8 && ($urandom % 2 == 0)) src.push_back(8'($urandom));
      r_v = ($urandom % 300 == 0);
      e_v = (src.size() == 0) || ($urandom % 5 == 0);
      d_v = e_v ? 8'($urandom) : src[0];
      f_v = ($urandom % 10 == 0);
      rdy_v = ($urandom % 2 == 0);
      pop_pred = !r_v && !m_valid && !e_v;
      step(r_v, e_v, d_v, f_v, rdy_v);
      if (pop_pred) void'(src.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
